// File: rtl/washer_controller.sv
// Washer cycle controller: phase FSM plus a 16-bit phase timer.
// Optional build macro: WM_LID_PAUSE_EN (lid-open pauses; otherwise it aborts).
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start, cancel    front-panel start / abort
//   lid              1 = lid open
//   mode1..mode3     quick / normal / heavy select (mode3 has priority)
//   state            FSM state code (IDLE=0 .. PAUSE=5)
//   phase_sel        current phase: 0 soak, 1 wash, 2 rinse, 3 spin
//   *_en             one-hot phase drives
//   timer_enable     timer is counting
//   timer_done       single-cycle phase-expiry strobe
//   counter_out      current phase count
module washer_controller #(
  parameter int unsigned SOAK_T  = 20,
  parameter int unsigned WASH_T  = 30,
  parameter int unsigned RINSE_T = 20,
  parameter int unsigned SPIN_T  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic        lid,
  input  logic        mode1,
  input  logic        mode2,
  input  logic        mode3,
  output logic [2:0]  state,
  output logic [1:0]  phase_sel,
  output logic        soak_en,
  output logic        wash_en,
  output logic        rinse_en,
  output logic        spin_en,
  output logic        timer_enable,
  output logic        timer_done,
  output logic [15:0] counter_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOAK  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    M_NONE   = 2'd0,
    M_QUICK  = 2'd1,
    M_NORMAL = 2'd2,
    M_HEAVY  = 2'd3
  } mode_t;

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d, mode_sel;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dur;
  logic        running;
  logic        done;

  always_comb begin
    mode_sel = M_NONE;
    if (mode3)      mode_sel = M_HEAVY;
    else if (mode2) mode_sel = M_NORMAL;
    else if (mode1) mode_sel = M_QUICK;
  end

  always_comb begin
    dur = 16'(SOAK_T);
    unique case (phase_q)
      2'd0: dur = 16'(SOAK_T);
      2'd1: dur = (mode_q == M_HEAVY) ? 16'(2 * WASH_T)
                                      : 16'(WASH_T);
      2'd2: dur = 16'(RINSE_T);
      2'd3: dur = 16'(SPIN_T);
      default: dur = 16'(SOAK_T);
    endcase
  end

  assign running = (state_q == SOAK) || (state_q == WASH) ||
                   (state_q == RINSE) || (state_q == SPIN);
  assign done    = running && (cnt_q == dur - 16'd1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d   = 16'd0;
        phase_d = 2'd0;
        mode_d  = M_NONE;
        if (start && !lid && (mode_sel != M_NONE)) begin
          mode_d = mode_sel;
          if (mode_sel == M_QUICK) begin
            state_d = WASH;
            phase_d = 2'd1;
          end else begin
            state_d = SOAK;
          end
        end
      end
      SOAK, WASH, RINSE, SPIN: begin
        if (cancel) begin
          state_d = IDLE;
          phase_d = 2'd0;
          mode_d  = M_NONE;
          cnt_d   = 16'd0;
        end else if (lid) begin
`ifdef WM_LID_PAUSE_EN
          // Counter and phase hold so the phase resumes exactly.
          state_d = PAUSE;
`else
          state_d = IDLE;
          phase_d = 2'd0;
          mode_d  = M_NONE;
          cnt_d   = 16'd0;
`endif
        end else if (done) begin
          cnt_d = 16'd0;
          if (state_q == SPIN) begin
            state_d = IDLE;
            phase_d = 2'd0;
            mode_d  = M_NONE;
          end else begin
            state_d = state_t'(state_q + 3'd1);
            phase_d = phase_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef WM_LID_PAUSE_EN
      PAUSE: begin
        if (cancel) begin
          state_d = IDLE;
          phase_d = 2'd0;
          mode_d  = M_NONE;
          cnt_d   = 16'd0;
        end else if (!lid) begin
          state_d = state_t'({1'b0, phase_q} + 3'd1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        phase_d = 2'd0;
        mode_d  = M_NONE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      mode_q  <= M_NONE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state        = state_q;
  assign phase_sel    = phase_q;
  assign soak_en      = running && (phase_q == 2'd0);
  assign wash_en      = running && (phase_q == 2'd1);
  assign rinse_en     = running && (phase_q == 2'd2);
  assign spin_en      = running && (phase_q == 2'd3);
  assign timer_enable = running;
  assign timer_done   = done;
  assign counter_out  = cnt_q;

endmodule

// File: tb/tb_washer_controller.sv
// Bench for washer_controller: directed plan steps then random traffic,
// all checked every cycle against a phase-list reference model.
module tb_washer_controller;

  localparam int ST = 20;
  localparam int WT = 30;
  localparam int RT = 20;
  localparam int PT = 15;

  logic        clk = 1'b0;
  logic        rst, start, cancel, lid;
  logic        mode1, mode2, mode3;
  logic [2:0]  state;
  logic [1:0]  phase_sel;
  logic        soak_en, wash_en, rinse_en, spin_en;
  logic        timer_enable, timer_done;
  logic [15:0] counter_out;

  int vectors = 0;
  int miscompares = 0;

  // reference model: active cycle = list of (phase, duration)
  bit m_active = 0;
  bit m_paused = 0;
  int m_phase[$];
  int m_dur[$];
  int m_idx = 0;
  int m_cnt = 0;

  int td_cnt, wash_cnt, max_wash;
  int lid_hold;

  washer_controller dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .lid(lid),
    .mode1(mode1), .mode2(mode2), .mode3(mode3),
    .state(state), .phase_sel(phase_sel),
    .soak_en(soak_en), .wash_en(wash_en),
    .rinse_en(rinse_en), .spin_en(spin_en),
    .timer_enable(timer_enable), .timer_done(timer_done),
    .counter_out(counter_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] model_out();
    int ph;
    logic te, td;
    logic [3:0] en;
    logic [2:0] st;
    if (!m_active) return 27'd0;
    ph = m_phase[m_idx];
    te = !m_paused;
    td = te && (m_cnt == m_dur[m_idx] - 1);
    en = te ? (4'b0001 << ph) : 4'b0000;
    st = m_paused ? 3'd5 : 3'(ph + 1);
    return {st, 2'(ph), en, te, td, 16'(m_cnt)};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 0;
      m_paused = 0;
      m_cnt = 0;
    end else if (!m_active) begin
      if (start && !lid && (mode1 || mode2 || mode3)) begin
        m_phase.delete();
        m_dur.delete();
        if (mode3 || mode2) begin
          m_phase.push_back(0);
          m_dur.push_back(ST);
        end
        m_phase.push_back(1);
        m_dur.push_back(mode3 ? 2 * WT : WT);
        m_phase.push_back(2);
        m_dur.push_back(RT);
        m_phase.push_back(3);
        m_dur.push_back(PT);
        m_active = 1;
        m_paused = 0;
        m_idx = 0;
        m_cnt = 0;
      end
    end else if (cancel) begin
      m_active = 0;
      m_paused = 0;
      m_cnt = 0;
    end else if (m_paused) begin
      if (!lid) m_paused = 0;
    end else if (lid) begin
`ifdef WM_LID_PAUSE_EN
      m_paused = 1;
`else
      m_active = 0;
      m_cnt = 0;
`endif
    end else if (m_cnt == m_dur[m_idx] - 1) begin
      m_cnt = 0;
      m_idx++;
      if (m_idx == m_phase.size()) m_active = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic tick();
    chk("outputs",
        64'({state, phase_sel, spin_en, rinse_en, wash_en, soak_en,
             timer_enable, timer_done, counter_out}),
        64'(model_out()));
    if (timer_done === 1'b1) td_cnt++;
    if (wash_en === 1'b1) wash_cnt++;
    if (state === 3'd2 && int'(counter_out) > max_wash)
      max_wash = int'(counter_out);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    start = 0; cancel = 0; lid = 0; rst = 0;
    mode1 = 0; mode2 = 0; mode3 = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    @(negedge clk);
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick();
    rst = 0;
    chk("reset_state", 64'(state), 64'd0);

    // quick cycle
    start = 1; mode1 = 1;
    tick();
    idle_in();
    td_cnt = 0; wash_cnt = 0;
    repeat (65) tick();
    chk("quick_done_pulses", 64'(td_cnt), 64'd3);
    chk("quick_wash_cycles", 64'(wash_cnt), 64'd30);
    chk("quick_end_idle", 64'(state), 64'd0);

    // heavy cycle with mode1 also set
    start = 1; mode3 = 1; mode1 = 1;
    tick();
    idle_in();
    max_wash = 0;
    repeat (116) tick();
    chk("heavy_wash_max", 64'(max_wash), 64'd59);
    chk("heavy_end_idle", 64'(state), 64'd0);

    // normal cycle, lid opened at wash count 10
    start = 1; mode2 = 1;
    tick();
    idle_in();
    repeat (30) tick();
    chk("lid_at_wash10", 64'({state, counter_out}), 64'({3'd2, 16'd10}));
    lid = 1;
    tick();
`ifdef WM_LID_PAUSE_EN
    chk("pause_hold", 64'({state, counter_out}), 64'({3'd5, 16'd10}));
`else
    chk("lid_abort", 64'({state, counter_out}), 64'd0);
`endif
    repeat (6) tick();
    lid = 0;
    repeat (70) tick();
    chk("normal_end_idle", 64'(state), 64'd0);

    // rejected starts
    start = 1; lid = 1; mode2 = 1;
    repeat (2) tick();
    chk("start_lid_open", 64'({state, timer_enable}), 64'd0);
    idle_in();
    start = 1;
    repeat (2) tick();
    chk("start_no_mode", 64'({state, timer_enable}), 64'd0);

    // cancel in rinse with simultaneous start
    idle_in();
    start = 1; mode1 = 1;
    tick();
    idle_in();
    repeat (35) tick();
    cancel = 1; start = 1; mode1 = 1;
    tick();
    idle_in();
    chk("cancel_rinse",
        64'({state, soak_en, wash_en, rinse_en, spin_en, counter_out}),
        64'd0);
    repeat (3) tick();

    // reset mid-soak
    start = 1; mode2 = 1;
    tick();
    idle_in();
    repeat (5) tick();
    rst = 1;
    repeat (10) tick();
    rst = 0;
    repeat (5) tick();
    chk("reset_mid_soak", 64'({state, phase_sel, counter_out}), 64'd0);

    // random traffic
    lid_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom % 15) == 0;
      cancel = ($urandom % 250) == 0;
      rst    = ($urandom % 900) == 0;
      mode1  = $urandom % 2;
      mode2  = ($urandom % 3) == 0;
      mode3  = ($urandom % 4) == 0;
      if (lid_hold > 0) begin
        lid = 1;
        lid_hold--;
      end else if (($urandom % 90) == 0) begin
        lid = 1;
        lid_hold = $urandom_range(0, 8);
      end else begin
        lid = 0;
      end
      tick();
    end
    idle_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/washer_controller.md
# washer_controller

Washing-machine cycle controller: a phase-sequencing FSM and a 16-bit multi-phase duration timer in one block. It runs soak, wash, rinse and spin phases according to a latched wash mode. It pauses on lid-open, aborts on cancel, and returns to IDLE when the cycle completes. It sits between the front-panel inputs and the motor/valve drivers, which consume the one-hot phase enables.

## Interface
- SOAK_T, 20: soak duration in clock cycles (1..65535).
- WASH_T, 30: wash duration in cycles; heavy mode uses 2*WASH_T, so 2*WASH_T must be ≤ 65535.
- RINSE_T, 20: rinse duration in cycles.
- SPIN_T, 15: spin duration in cycles.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level/pulse; begins a cycle from IDLE.
- cancel  in  1  aborts the cycle to IDLE.
- lid  in  1  1 = lid open.
- mode1  in  1  quick mode.
- mode2  in  1  normal mode.
- mode3  in  1  heavy mode.
- state  out  3  FSM state code.
- phase_sel  out  2  current phase: 00 soak, 01 wash, 10 rinse, 11 spin.
- soak_en, wash_en, rinse_en, spin_en  out  1 each  one-hot phase drive.
- timer_enable  out  1  timer counting.
- timer_done  out  1  single-cycle phase-expiry strobe.
- counter_out  out  16  current phase count.

## Operation
State codes:
- IDLE = 0, SOAK = 1, WASH = 2, RINSE = 3, SPIN = 4, PAUSE = 5.
- Codes 6 and 7 are illegal and go to IDLE on the next edge.

Starting a cycle:
- Start is accepted only in IDLE, with lid = 0 and at least one mode bit set. Otherwise it is ignored.
- Mode priority: mode3 > mode2 > mode1. The mode is latched at start; mode inputs are ignored while running.

Phase sequences:
- Quick: WASH → RINSE → SPIN.
- Normal: SOAK → WASH → RINSE → SPIN.
- Heavy: SOAK → WASH (2*WASH_T) → RINSE → SPIN.
- timer_done at the end of SPIN returns the FSM to IDLE.

Outputs by state:
- Running states: exactly one phase enable is high (matching phase_sel), and timer_enable = 1.
- IDLE and PAUSE: all enables are 0 and timer_enable = 0.
- phase_sel is 00 in IDLE and holds its value during PAUSE.

Timer:
- Selects its duration D from phase_sel and the latched mode.
- counter_out increments by 1 each cycle while timer_enable = 1.
- timer_done = timer_enable && (counter_out == D-1), combinationally.
- On the edge where timer_done = 1, the counter clears to 0 and the FSM advances.
- The counter holds while timer_enable = 0 in PAUSE, and is forced to 0 in IDLE.

Lid, cancel and start while running:
- lid = 1 in any running state → PAUSE on the next edge.
- lid = 0 in PAUSE → resume the saved phase with the counter unchanged.
- cancel = 1 in any non-IDLE state → IDLE; the counter clears and the mode latch clears.
- start while not in IDLE is ignored.

## Timing
- Reset value of every output is 0: state = IDLE, phase_sel = 00, all enables 0, counter_out = 0, timer_done = 0.
- Start sampled high in IDLE → first phase state at the next edge. counter_out reads 0 in the first cycle of the phase.
- Each phase lasts exactly D cycles; counter_out runs 0..D-1.
- Total running cycles: quick 65, normal 85, heavy 115 (default parameters).

Simultaneous events:
- rst beats everything; cancel beats lid; lid beats timer_done.
- Lid opens in the same cycle as timer_done: enter PAUSE with the counter held at D-1. timer_done fires in the first cycle after resume.
- Reset mid-cycle: IDLE at the next edge. The cycle is not resumed, and start is required again.

## Configuration
- WM_LID_PAUSE_EN defined: lid-open pauses the cycle as described, using the PAUSE state.
- WM_LID_PAUSE_EN undefined: the PAUSE state is not implemented, and lid = 1 in a running state behaves exactly like cancel (→ IDLE).
- Start still requires lid = 0 in both builds.

## Test plan
- Reset, then start + mode1 with lid = 0 → state sequence 2 (30 cycles), 3 (20 cycles), 4 (15 cycles), then 0. Exactly 3 timer_done pulses; wash_en is high for exactly 30 cycles.
- Start + mode3 (mode1 also high) → heavy sequence 1, 2, 3, 4. WASH counter_out reaches 59 before timer_done.
- Normal mode; lid = 1 at WASH counter_out = 10 for 7 cycles → state 5 and counter holds 10; on resume counter continues from 10, total WASH time = 30 active cycles.
- Start with lid = 1, or with no mode bit set → state stays 0 and timer_enable stays 0.
- cancel pulse during RINSE → IDLE next edge, counter_out = 0, all enables 0. A second start on the same edge as cancel is ignored.
- rst asserted mid-SOAK for 10 cycles → all outputs 0 and state 0. After release, the block stays IDLE until start.
